osc_model: RTL

Emulated-time clock oscillator for the multi-clock emulation flow. Sits directly upstream of the oscillator checkers: it consumes per-oscillator `t_lo`/`t_hi` half-period settings (in `DT_SCALE` units, as produced by the simulation controller). It publishes a timestep request to the global time manager, tracks the granted step `emu_dt`, and produces the emulated clock level plus a clock-enable pulse for logic running on `emu_clk`.

---
 rtl/osc_model.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/osc_model.sv
`default_nettype none
// ============================================================================
//  Module      : osc_model
//  Description : Emulated-time clock oscillator. Requests the time left until
//                its next edge from the global time manager (dt_req). It
//                consumes the granted step (emu_dt), which is the minimum over
//                all oscillators. It toggles the emulated clock level (clk_o)
//                when its half-period expires. cke_o is a clock-enable for
//                logic clocked by emu_clk that must act on emulated rising
//                edges.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DT_WIDTH   : width of t_lo, t_hi, emu_dt, dt_req (unsigned DT_SCALE units)
//    CNT_WIDTH  : width of the rising-edge counter n_rise
//  Ports
//    emu_clk    : in  emulator clock, all state changes on its rising edge
//    emu_rst_n  : in  asynchronous active-low reset
//    t_lo       : in  low half-period, sampled only when a LO phase starts
//    t_hi       : in  high half-period, sampled only when a HI phase starts
//    emu_dt     : in  timestep granted this cycle
//    dt_req     : out time remaining to this oscillator's next edge
//                     (all-ones while in INIT so it never limits the step)
//    clk_o      : out emulated clock level
//    cke_o      : out high in the cycle whose update creates a rising edge
//    n_rise     : out rising edges since reset, wraps
//    err        : out sticky overshoot flag (emu_dt > remaining time)
//  Compile-time options
//    OSC_MODEL_CHECK_EN : when defined, overshoot detection drives err and
//                         reports in simulation; otherwise err is tied low.
// ============================================================================
module osc_model #(
    parameter int DT_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst_n,
    input  logic [DT_WIDTH-1:0]  t_lo,
    input  logic [DT_WIDTH-1:0]  t_hi,
    input  logic [DT_WIDTH-1:0]  emu_dt,
    output logic [DT_WIDTH-1:0]  dt_req,
    output logic                 clk_o,
    output logic                 cke_o,
    output logic [CNT_WIDTH-1:0] n_rise,
    output logic                 err
);

    localparam logic [DT_WIDTH-1:0]  C_DT_ONE   = DT_WIDTH'(1);
    localparam logic [DT_WIDTH-1:0]  C_DT_ZERO  = '0;
    localparam logic [DT_WIDTH-1:0]  C_DT_ONES  = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [DT_WIDTH-1:0]    r_t_rem;
    logic                   r_clk;
    logic [CNT_WIDTH-1:0]   r_n_rise;

    logic [DT_WIDTH-1:0]    w_lo_eff;
    logic [DT_WIDTH-1:0]    w_hi_eff;
    logic                   w_expire;
    logic                   w_running;

    // A zero half-period would request a zero step and stall every oscillator
    // sharing the time manager, so it is clamped to one unit.
    assign w_lo_eff  = (t_lo == C_DT_ZERO) ? C_DT_ONE : t_lo;
    assign w_hi_eff  = (t_hi == C_DT_ZERO) ? C_DT_ONE : t_hi;

    // The >= compare also covers overshoot, so the subtraction below only
    // ever runs with emu_dt < r_t_rem and cannot underflow.
    assign w_expire  = (emu_dt >= r_t_rem);
    assign w_running = (r_state == ST_LO) || (r_state == ST_HI);

    // ------------------------------------------------------------------------
    // Oscillator state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            r_state  <= ST_INIT;
            r_t_rem  <= C_DT_ZERO;
            r_clk    <= 1'b0;
            r_n_rise <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // The granted step is meaningless before the first
                    // request has been published, so it is ignored here.
                    r_state <= ST_LO;
                    r_t_rem <= w_lo_eff;
                    r_clk   <= 1'b0;
                end
                ST_LO: begin
                    if (w_expire) begin
                        // Any excess beyond r_t_rem is dropped: the high
                        // phase always starts with its full length.
                        r_state  <= ST_HI;
                        r_clk    <= 1'b1;
                        r_t_rem  <= w_hi_eff;
                        r_n_rise <= r_n_rise + C_CNT_ONE;
                    end else begin
                        r_t_rem  <= r_t_rem - emu_dt;
                    end
                end
                ST_HI: begin
                    if (w_expire) begin
                        r_state <= ST_LO;
                        r_clk   <= 1'b0;
                        r_t_rem <= w_lo_eff;
                    end else begin
                        r_t_rem <= r_t_rem - emu_dt;
                    end
                end
                default: begin
                    // Unreachable encoding: restart through INIT.
                    r_state <= ST_INIT;
                    r_t_rem <= C_DT_ZERO;
                    r_clk   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // dt_req depends only on registers, so the time manager can compute the
    // global minimum without a loop through emu_dt.
    assign dt_req = w_running ? r_t_rem : C_DT_ONES;
    assign clk_o  = r_clk;
    assign n_rise = r_n_rise;
    assign cke_o  = (r_state == ST_LO) && w_expire;

    // ------------------------------------------------------------------------
    // Optional overshoot check
    // ------------------------------------------------------------------------
`ifdef OSC_MODEL_CHECK_EN
    logic w_overshoot;
    logic r_err;

    assign w_overshoot = w_running && (emu_dt > r_t_rem);

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            r_err <= 1'b0;
        end else if (w_overshoot) begin
            r_err <= 1'b1;
`ifndef SYNTHESIS
            $error("osc_model: overshoot, t_rem=%0d emu_dt=%0d", r_t_rem, emu_dt);
`endif
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire
